multicycle_ctrl: RTL
====================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-003 inst  input  32  current instruction register contents (op=inst[31:26], func=inst[5:0]).
REQ-004 zero  input  1  ALU zero flag, sampled in EXEC.
REQ-005 mem_ready  input  1  memory acknowledge for fetch and data access; zero-wait (same-cycle) allowed.
REQ-006 im_r  output  1  instruction fetch request.
REQ-007 ir_w  output  1  instruction register load strobe.
REQ-008 pc_w  output  1  PC write enable.
REQ-009 pc_src  output  2  PC source: 00 PC+4, 01 branch target, 10 jump target.
REQ-010 aluc  output  4  ALU operation code.
REQ-011 alu_srcb  output  1  ALU B operand: 0 register, 1 extended immediate.
REQ-012 sign_ext  output  1  immediate extension: 1 sign, 0 zero.
REQ-013 rf_w  output  1  register file write enable.
REQ-014 wb_sel  output  2  write-back source: 00 ALU, 01 lui, 10 memory, 11 slti.
REQ-015 dm_cs, dm_r, dm_w  output  1 each  data memory select, read, write.
REQ-016 illegal  output  1  one-cycle pulse on unsupported opcode/func.
REQ-017 state  output  3  current FSM state, for debug.
REQ-018 retired  output  32  count of completed instructions.

Function
REQ-019 States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4; other codes unreachable and SHALL return to FETCH.
REQ-020 FETCH: im_r=1 until mem_ready; on mem_ready: ir_w=1, pc_w=1, pc_src=00, next DECODE; otherwise stay.
REQ-021 DECODE: j -> pc_w=1, pc_src=10, next FETCH; inst==0 (nop) -> next FETCH; unsupported -> illegal=1, next FETCH; else next EXEC.
REQ-022 Supported: add, sub, and, or, xor, nor, sll, srl, addiu, andi, ori, xori, slti, lui, lw, sw, beq, j.
REQ-023 EXEC: aluc valid; beq -> pc_w=zero, pc_src=01, next FETCH; lw/sw -> MEM; all others -> WB.
REQ-024 aluc: addiu/lw/sw/lui 0000, add 0010, sub/beq/slti 0001, and/andi 0011, or/ori 0100, nor 0101, xor/xori 0110, sll 1000, srl 1001; 0000 outside EXEC.
REQ-025 alu_srcb=1 for addiu, andi, ori, xori, slti, lui, lw, sw; sign_ext=1 for lw, sw, slti, addiu, beq.
REQ-026 MEM: dm_cs=1 plus dm_r (lw) or dm_w (sw), held constant until mem_ready; on mem_ready sw -> FETCH, lw -> WB.
REQ-027 WB: rf_w=1 for exactly one cycle, wb_sel per REQ-014 (lw 10, lui 01, slti 11, else 00), next FETCH.
REQ-028 Outputs not listed as active for a state SHALL be 0.
REQ-029 retired increments by 1 on every transition into FETCH except the illegal path; wraps 0xFFFFFFFF -> 0.
REQ-030 Latencies with zero-wait memory: j/nop 2 cycles; beq 3; R-type/immediate 4; sw 4; lw 5.

Reset
REQ-031 rst sampled high: next state FETCH, retired=0.
REQ-032 All outputs except state/retired SHALL be 0 combinationally while rst is high, including mid-MEM (dm_cs/dm_w drop immediately).
REQ-033 First im_r asserted in the first cycle after rst is sampled low.

Structure
REQ-034 Shared package holds state encodings, opcode/func constants, aluc and wb_sel codes.
REQ-035 One sub-module, ctrl_decode: combinational instruction classification (type flags, aluc, alu_srcb, sign_ext, wb_sel, illegal); FSM and counter stay in multicycle_ctrl.

Verification
REQ-036 add 0x00221820, mem_ready=1: states 0,1,2,4; aluc=0010 in EXEC; rf_w, wb_sel=00 in WB; retired 0->1.
REQ-037 lw 0x8C220004, mem_ready low 3 cycles in MEM: dm_cs=dm_r=1 for 4 cycles, then WB with wb_sel=10; sign_ext=1.
REQ-038 beq 0x10220003: zero=1 -> pc_w=1, pc_src=01 in EXEC; zero=0 -> pc_w=0; both 3 cycles, retired +1.
REQ-039 j 0x08000010: pc_w=1, pc_src=10 in DECODE, back to FETCH; 0x00000000: 2 cycles, retired +1.
REQ-040 0xFC000000: illegal pulses once in DECODE, retired unchanged; FETCH mem_ready held low 5 cycles: im_r stays 1, no ir_w.
REQ-041 rst high during sw MEM: dm_w=0 same cycle, next state FETCH, retired=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared constants for the multicycle MIPS-subset controller: FSM state
// encodings, opcode/func field values, ALU operation codes, write-back
// source selects and PC source selects.
// ---------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    // FSM state encodings (3-bit, debug-visible on the state port)
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    // Primary opcodes, inst[31:26]
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes, inst[5:0]
    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_NOR = 6'h27;

    // ALU operation codes
    localparam logic [3:0] ALU_ADDU = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_AND  = 4'b0011;
    localparam logic [3:0] ALU_OR   = 4'b0100;
    localparam logic [3:0] ALU_NOR  = 4'b0101;
    localparam logic [3:0] ALU_XOR  = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;

    // Write-back source selects
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_LUI  = 2'b01;
    localparam logic [1:0] WB_MEM  = 2'b10;
    localparam logic [1:0] WB_SLTI = 2'b11;

    // PC source selects
    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_decode.sv
// ---------------------------------------------------------------------------
// ctrl_decode
// Purely combinational instruction classifier for multicycle_ctrl.
// Ports:
//   inst_i      instruction register contents
//   is_j_o      jump
//   is_nop_o    all-zero instruction
//   is_beq_o    branch-if-equal
//   is_lw_o     load word
//   is_sw_o     store word
//   illegal_o   opcode/func not in the supported set
//   aluc_o      ALU operation for this instruction
//   alu_srcb_o  1 = immediate B operand
//   sign_ext_o  1 = sign-extend immediate
//   wb_sel_o    write-back source for this instruction
// ---------------------------------------------------------------------------
module ctrl_decode
    import multicycle_ctrl_pkg::*;
(
    input  logic [31:0] inst_i,
    output logic        is_j_o,
    output logic        is_nop_o,
    output logic        is_beq_o,
    output logic        is_lw_o,
    output logic        is_sw_o,
    output logic        illegal_o,
    output logic [3:0]  aluc_o,
    output logic        alu_srcb_o,
    output logic        sign_ext_o,
    output logic [1:0]  wb_sel_o
);

    logic [5:0] op;
    logic [5:0] func;
    logic       supported;

    assign op       = inst_i[31:26];
    assign func     = inst_i[5:0];
    assign is_nop_o = (inst_i == 32'd0);

    always_comb begin
        supported  = 1'b1;
        is_j_o     = 1'b0;
        is_beq_o   = 1'b0;
        is_lw_o    = 1'b0;
        is_sw_o    = 1'b0;
        aluc_o     = ALU_ADDU;
        alu_srcb_o = 1'b0;
        sign_ext_o = 1'b0;
        wb_sel_o   = WB_ALU;
        case (op)
            OP_RTYPE: begin
                case (func)
                    FN_ADD:  aluc_o = ALU_ADD;
                    FN_SUB:  aluc_o = ALU_SUB;
                    FN_AND:  aluc_o = ALU_AND;
                    FN_OR:   aluc_o = ALU_OR;
                    FN_XOR:  aluc_o = ALU_XOR;
                    FN_NOR:  aluc_o = ALU_NOR;
                    FN_SLL:  aluc_o = ALU_SLL;
                    FN_SRL:  aluc_o = ALU_SRL;
                    default: supported = 1'b0;
                endcase
            end
            OP_J:    is_j_o = 1'b1;
            OP_BEQ: begin
                is_beq_o   = 1'b1;
                aluc_o     = ALU_SUB;
                sign_ext_o = 1'b1;
            end
            OP_ADDIU: begin
                alu_srcb_o = 1'b1;
                sign_ext_o = 1'b1;
            end
            OP_SLTI: begin
                // slti compares by subtraction; the result bit is picked at write-back
                aluc_o     = ALU_SUB;
                alu_srcb_o = 1'b1;
                sign_ext_o = 1'b1;
                wb_sel_o   = WB_SLTI;
            end
            OP_ANDI: begin
                aluc_o     = ALU_AND;
                alu_srcb_o = 1'b1;
            end
            OP_ORI: begin
                aluc_o     = ALU_OR;
                alu_srcb_o = 1'b1;
            end
            OP_XORI: begin
                aluc_o     = ALU_XOR;
                alu_srcb_o = 1'b1;
            end
            OP_LUI: begin
                alu_srcb_o = 1'b1;
                wb_sel_o   = WB_LUI;
            end
            OP_LW: begin
                is_lw_o    = 1'b1;
                alu_srcb_o = 1'b1;
                sign_ext_o = 1'b1;
                wb_sel_o   = WB_MEM;
            end
            OP_SW: begin
                is_sw_o    = 1'b1;
                alu_srcb_o = 1'b1;
                sign_ext_o = 1'b1;
            end
            default: supported = 1'b0;
        endcase
    end

    assign illegal_o = ~supported;

endmodule

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
// Five-state (FETCH/DECODE/EXEC/MEM/WB) control FSM for a multicycle
// MIPS-subset datapath, with a retired-instruction counter.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   inst               instruction register contents
//   zero               ALU zero flag (branch decision in EXEC)
//   mem_ready          memory acknowledge for fetch and data access
//   im_r, ir_w         instruction fetch request, IR load strobe
//   pc_w, pc_src       PC write enable and source select
//   aluc, alu_srcb     ALU op and B operand select (valid in EXEC)
//   sign_ext           immediate extension mode (valid in EXEC)
//   rf_w, wb_sel       register write enable and source (WB)
//   dm_cs, dm_r, dm_w  data memory select/read/write (MEM)
//   illegal            one-cycle pulse in DECODE on unsupported instruction
//   state              current FSM state (debug)
//   retired            completed-instruction count
// ---------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        im_r,
    output logic        ir_w,
    output logic        pc_w,
    output logic [1:0]  pc_src,
    output logic [3:0]  aluc,
    output logic        alu_srcb,
    output logic        sign_ext,
    output logic        rf_w,
    output logic [1:0]  wb_sel,
    output logic        dm_cs,
    output logic        dm_r,
    output logic        dm_w,
    output logic        illegal,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    logic [2:0]  state_q, state_d;
    logic [31:0] retired_q, retired_d;
    logic        retire;

    logic        dec_is_j, dec_is_nop, dec_is_beq, dec_is_lw, dec_is_sw, dec_illegal;
    logic [3:0]  dec_aluc;
    logic        dec_alu_srcb, dec_sign_ext;
    logic [1:0]  dec_wb_sel;

    ctrl_decode u_decode (
        .inst_i     (inst),
        .is_j_o     (dec_is_j),
        .is_nop_o   (dec_is_nop),
        .is_beq_o   (dec_is_beq),
        .is_lw_o    (dec_is_lw),
        .is_sw_o    (dec_is_sw),
        .illegal_o  (dec_illegal),
        .aluc_o     (dec_aluc),
        .alu_srcb_o (dec_alu_srcb),
        .sign_ext_o (dec_sign_ext),
        .wb_sel_o   (dec_wb_sel)
    );

    always_comb begin
        state_d  = state_q;
        retire   = 1'b0;
        im_r     = 1'b0;
        ir_w     = 1'b0;
        pc_w     = 1'b0;
        pc_src   = PC_SEQ;
        aluc     = ALU_ADDU;
        alu_srcb = 1'b0;
        sign_ext = 1'b0;
        rf_w     = 1'b0;
        wb_sel   = WB_ALU;
        dm_cs    = 1'b0;
        dm_r     = 1'b0;
        dm_w     = 1'b0;
        illegal  = 1'b0;

        case (state_q)
            S_FETCH: begin
                im_r = 1'b1;
                if (mem_ready) begin
                    ir_w    = 1'b1;
                    pc_w    = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (dec_is_j) begin
                    pc_w    = 1'b1;
                    pc_src  = PC_JUMP;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_is_nop) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_illegal) begin
                    // Illegal instructions are abandoned without counting as retired
                    illegal = 1'b1;
                    state_d = S_FETCH;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                aluc     = dec_aluc;
                alu_srcb = dec_alu_srcb;
                sign_ext = dec_sign_ext;
                if (dec_is_beq) begin
                    pc_w    = zero;
                    pc_src  = PC_BRANCH;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end else if (dec_is_lw || dec_is_sw) begin
                    state_d = S_MEM;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                dm_cs = 1'b1;
                dm_r  = dec_is_lw;
                dm_w  = dec_is_sw;
                if (mem_ready) begin
                    if (dec_is_sw) begin
                        retire  = 1'b1;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                rf_w    = 1'b1;
                wb_sel  = dec_wb_sel;
                retire  = 1'b1;
                state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // Reset kills every strobe immediately, even in the middle of a memory access
        if (rst) begin
            im_r     = 1'b0;
            ir_w     = 1'b0;
            pc_w     = 1'b0;
            pc_src   = PC_SEQ;
            aluc     = ALU_ADDU;
            alu_srcb = 1'b0;
            sign_ext = 1'b0;
            rf_w     = 1'b0;
            wb_sel   = WB_ALU;
            dm_cs    = 1'b0;
            dm_r     = 1'b0;
            dm_w     = 1'b0;
            illegal  = 1'b0;
        end
    end

    assign retired_d = retired_q + {31'd0, retire};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
